// File: rtl/rotor_stepper.sv
// rotor_stepper
// Upstream stage of the rotor datapath. Accepts one plaintext symbol per
// keypress, advances the three rotor positions (with double-stepping) and
// then presents the symbol plus the post-step positions to the combinational
// rotor path until the downstream stage consumes it.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   load_en      load initial rotor positions (honoured only in IDLE)
//   load_r0/1/2  rotor load values; values >= NUM_SYMBOLS load as 0
//   in_valid     keypress symbol valid
//   in_data      keypress symbol
//   in_ready     block can accept a symbol (IDLE)
//   out_valid    data_out and positions valid for the rotor path (OUT)
//   out_ready    downstream consumed the symbol
//   data_out     latched symbol
//   r0_position  fast rotor position
//   r1_position  middle rotor position
//   r2_position  slow rotor position
//
// state | meaning
// IDLE  | ready for a keypress or a position load
// STEP  | one-cycle rotor advance on the latched symbol
// OUT   | symbol and positions presented, held until out_ready
module rotor_stepper #(
    parameter int NUM_SYMBOLS = 64,
    parameter int R0_NOTCH    = 16,
    parameter int R1_NOTCH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_en,
    input  logic [5:0] load_r0,
    input  logic [5:0] load_r1,
    input  logic [5:0] load_r2,
    input  logic       in_valid,
    input  logic [5:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] data_out,
    output logic [5:0] r0_position,
    output logic [5:0] r1_position,
    output logic [5:0] r2_position
);

    localparam logic [5:0] LAST_POS  = 6'(NUM_SYMBOLS - 1);
    localparam logic [6:0] NUM_SYM_W = 7'(NUM_SYMBOLS);
    localparam logic [5:0] N0        = 6'(R0_NOTCH);
    localparam logic [5:0] N1        = 6'(R1_NOTCH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] r0_q, r0_d;
    logic [5:0] r1_q, r1_d;
    logic [5:0] r2_q, r2_d;
    logic [5:0] data_q, data_d;

    function automatic logic [5:0] inc_pos(input logic [5:0] v);
        return (v == LAST_POS) ? 6'd0 : v + 6'd1;
    endfunction

    // Out-of-range load values fall back to position 0.
    function automatic logic [5:0] clamp_pos(input logic [5:0] v);
        return ({1'b0, v} >= NUM_SYM_W) ? 6'd0 : v;
    endfunction

    always_comb begin
        state_d   = state_q;
        r0_d      = r0_q;
        r1_d      = r1_q;
        r2_d      = r2_q;
        data_d    = data_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (load_en) begin
                    r0_d = clamp_pos(load_r0);
                    r1_d = clamp_pos(load_r1);
                    r2_d = clamp_pos(load_r2);
                end else if (in_valid) begin
                    data_d  = in_data;
                    state_d = STEP;
                end
            end
            STEP: begin
                // All conditions use pre-step values; r1 at its notch steps
                // itself as well as r2 (double step).
                r0_d = inc_pos(r0_q);
                if ((r0_q == N0) || (r1_q == N1)) begin
                    r1_d = inc_pos(r1_q);
                end
                if (r1_q == N1) begin
                    r2_d = inc_pos(r2_q);
                end
                state_d = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r0_q    <= 6'd0;
            r1_q    <= 6'd0;
            r2_q    <= 6'd0;
            data_q  <= 6'd0;
        end else begin
            state_q <= state_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            data_q  <= data_d;
        end
    end

    assign data_out    = data_q;
    assign r0_position = r0_q;
    assign r1_position = r1_q;
    assign r2_position = r2_q;

endmodule

// File: tb/tb_rotor_stepper.sv
// Testbench for rotor_stepper. Two instances share all inputs: one with the
// default 64-symbol alphabet, one with a 40-symbol alphabet so out-of-range
// loads and the smaller wrap point can be exercised on 6-bit ports.
module tb_rotor_stepper;

    localparam int NA = 64;
    localparam int NB = 40;
    localparam int NOTCH0 = 16;
    localparam int NOTCH1 = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_en = 1'b0;
    logic [5:0] load_r0 = '0, load_r1 = '0, load_r2 = '0;
    logic       in_valid = 1'b0;
    logic [5:0] in_data = '0;
    logic       out_ready = 1'b0;

    logic       ir_a, ov_a, ir_b, ov_b;
    logic [5:0] d_a, p0_a, p1_a, p2_a;
    logic [5:0] d_b, p0_b, p1_b, p2_b;

    always #5 clk = ~clk;

    rotor_stepper #(.NUM_SYMBOLS(NA), .R0_NOTCH(NOTCH0), .R1_NOTCH(NOTCH1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .load_en(load_en),
        .load_r0(load_r0), .load_r1(load_r1), .load_r2(load_r2),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir_a),
        .out_valid(ov_a), .out_ready(out_ready), .data_out(d_a),
        .r0_position(p0_a), .r1_position(p1_a), .r2_position(p2_a)
    );

    rotor_stepper #(.NUM_SYMBOLS(NB), .R0_NOTCH(NOTCH0), .R1_NOTCH(NOTCH1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .load_en(load_en),
        .load_r0(load_r0), .load_r1(load_r1), .load_r2(load_r2),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir_b),
        .out_valid(ov_b), .out_ready(out_ready), .data_out(d_b),
        .r0_position(p0_b), .r1_position(p1_b), .r2_position(p2_b)
    );

    // Status as {in_ready_a, out_valid_a, in_ready_b, out_valid_b}.
    localparam logic [3:0] ST_IDLE = 4'b1010;
    localparam logic [3:0] ST_BUSY = 4'b0000;
    localparam logic [3:0] ST_OUT  = 4'b0101;

    logic [3:0]  status;
    logic [35:0] pos_act;
    logic [11:0] data_act;
    assign status   = {ir_a, ov_a, ir_b, ov_b};
    assign pos_act  = {p0_a, p1_a, p2_a, p0_b, p1_b, p2_b};
    assign data_act = {d_a, d_b};

    int errors = 0;
    int checks = 0;

    // Reference model: rotor positions per alphabet size, last accepted symbol.
    int mp [2][3];
    int msym;

    function automatic int nsym(input int k);
        return (k == 0) ? NA : NB;
    endfunction

    function automatic logic [35:0] exp_pos();
        return {6'(mp[0][0]), 6'(mp[0][1]), 6'(mp[0][2]),
                6'(mp[1][0]), 6'(mp[1][1]), 6'(mp[1][2])};
    endfunction

    function automatic logic [11:0] exp_data();
        return {6'(msym), 6'(msym)};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) for (int i = 0; i < 3; i++) mp[k][i] = 0;
        msym = 0;
    endtask

    task automatic model_load(input int a, input int b, input int c);
        for (int k = 0; k < 2; k++) begin
            mp[k][0] = (a >= nsym(k)) ? 0 : a;
            mp[k][1] = (b >= nsym(k)) ? 0 : b;
            mp[k][2] = (c >= nsym(k)) ? 0 : c;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int n  = nsym(k);
            bit s1 = (mp[k][0] == NOTCH0) || (mp[k][1] == NOTCH1);
            bit s2 = (mp[k][1] == NOTCH1);
            mp[k][0] = (mp[k][0] + 1) % n;
            if (s1) mp[k][1] = (mp[k][1] + 1) % n;
            if (s2) mp[k][2] = (mp[k][2] + 1) % n;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int a, input int b, input int c, input string nm);
        load_en  = 1'b1;
        load_r0  = 6'(a);
        load_r1  = 6'(b);
        load_r2  = 6'(c);
        in_valid = 1'b1;
        in_data  = 6'($urandom);
        cyc();
        model_load(a, b, c);
        load_en  = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (status !== ST_IDLE) begin
            errors++;
            $display("FAIL %s load status: got %b want %b", nm, status, ST_IDLE);
        end
        checks++;
        if (pos_act !== exp_pos()) begin
            errors++;
            $display("FAIL %s load positions: got %h want %h", nm, pos_act, exp_pos());
        end
    endtask

    // One keypress transaction starting from IDLE; bp = cycles of out_ready=0 in OUT.
    task automatic do_symbol(input logic [5:0] sym, input int bp, input string nm);
        checks++;
        if (status !== ST_IDLE) begin
            errors++;
            $display("FAIL %s pre status: got %b want %b", nm, status, ST_IDLE);
        end
        in_valid  = 1'b1;
        in_data   = sym;
        load_en   = 1'b0;
        out_ready = 1'($urandom);
        cyc();
        msym = sym;
        in_valid  = 1'($urandom);
        in_data   = 6'($urandom);
        load_en   = 1'($urandom);
        load_r0   = 6'($urandom);
        out_ready = 1'($urandom);
        checks++;
        if (status !== ST_BUSY) begin
            errors++;
            $display("FAIL %s step status: got %b want %b", nm, status, ST_BUSY);
        end
        cyc();
        model_step();
        for (int i = 0; i <= bp; i++) begin
            out_ready = (i == bp);
            in_valid  = ~in_valid;
            load_en   = 1'($urandom);
            load_r0   = 6'($urandom);
            load_r1   = 6'($urandom);
            load_r2   = 6'($urandom);
            checks++;
            if (status !== ST_OUT) begin
                errors++;
                $display("FAIL %s out status[%0d]: got %b want %b", nm, i, status, ST_OUT);
            end
            checks++;
            if (data_act !== exp_data()) begin
                errors++;
                $display("FAIL %s out data[%0d]: got %h want %h", nm, i, data_act, exp_data());
            end
            checks++;
            if (pos_act !== exp_pos()) begin
                errors++;
                $display("FAIL %s out positions[%0d]: got %h want %h", nm, i, pos_act, exp_pos());
            end
            cyc();
        end
        in_valid  = 1'b0;
        load_en   = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (status !== ST_IDLE || pos_act !== exp_pos()) begin
            errors++;
            $display("FAIL %s post idle: got %b/%h want %b/%h", nm, status, pos_act, ST_IDLE, exp_pos());
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 6'd9;
        load_en   = 1'b1;
        load_r0   = 6'd7;
        out_ready = 1'b1;
        cyc();
        cyc();
        model_reset();
        in_valid  = 1'b0;
        load_en   = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        repeat (5) cyc();
        checks++;
        if (status !== ST_IDLE) begin
            errors++;
            $display("FAIL reset status: got %b want %b", status, ST_IDLE);
        end
        checks++;
        if (pos_act !== exp_pos()) begin
            errors++;
            $display("FAIL reset positions: got %h want %h", pos_act, exp_pos());
        end
        checks++;
        if (data_act !== exp_data()) begin
            errors++;
            $display("FAIL reset data: got %h want %h", data_act, exp_data());
        end
    endtask

    task automatic test_first_symbol();
        do_symbol(6'd6, 0, "first");
        checks++;
        if (pos_act !== {6'd1, 6'd0, 6'd0, 6'd1, 6'd0, 6'd0}) begin
            errors++;
            $display("FAIL first abs positions: got %h want (1,0,0)x2", pos_act);
        end
    endtask

    task automatic test_notches();
        do_load(16, 0, 0, "notch_r0");
        do_symbol(6'd11, 1, "notch_r0");
        do_load(63, 0, 0, "wrap63");
        do_symbol(6'd12, 0, "wrap63");
        do_load(39, 0, 0, "wrap39");
        do_symbol(6'd13, 0, "wrap39");
        do_load(16, 3, 0, "dbl_a");
        do_symbol(6'd14, 0, "dbl_a");
        do_symbol(6'd15, 2, "dbl_b");
        checks++;
        if ({p0_a, p1_a, p2_a} !== {6'd18, 6'd5, 6'd1}) begin
            errors++;
            $display("FAIL double step abs: got %h want (18,5,1)", {p0_a, p1_a, p2_a});
        end
    endtask

    task automatic test_clamp();
        do_load(50, 5, 63, "clamp");
        do_symbol(6'd33, 0, "clamp");
        do_load(63, 63, 63, "wrap_all");
        do_symbol(6'd34, 1, "wrap_all");
    endtask

    task automatic test_backpressure();
        do_load(20, 4, 62, "bp");
        do_symbol(6'd42, 6, "bp");
        cyc();
        checks++;
        if (status !== ST_IDLE || pos_act !== exp_pos()) begin
            errors++;
            $display("FAIL bp single handshake: got %b/%h want %b/%h", status, pos_act, ST_IDLE, exp_pos());
        end
    endtask

    task automatic test_reset_mid(input bit in_out, input string nm);
        do_load(10, 4, 2, nm);
        in_valid = 1'b1;
        in_data  = 6'd55;
        cyc();
        in_valid = 1'b0;
        if (in_out) cyc();
        rst_n     = 1'b0;
        out_ready = 1'b0;
        cyc();
        rst_n = 1'b1;
        model_reset();
        checks++;
        if (status !== ST_IDLE) begin
            errors++;
            $display("FAIL %s status: got %b want %b", nm, status, ST_IDLE);
        end
        checks++;
        if (pos_act !== exp_pos() || data_act !== exp_data()) begin
            errors++;
            $display("FAIL %s state: got %h/%h want %h/%h", nm, pos_act, data_act, exp_pos(), exp_data());
        end
        out_ready = 1'b1;
        repeat (3) begin
            cyc();
            checks++;
            if (status !== ST_IDLE) begin
                errors++;
                $display("FAIL %s pending presented: got %b want %b", nm, status, ST_IDLE);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int picks [7] = '{15, 16, 63, 3, 4, 39, 0};
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                int a = $urandom_range(0, 7);
                int b = $urandom_range(0, 7);
                int r0v = (a < 7) ? picks[a] : int'($urandom_range(0, 63));
                int r1v = (b < 7) ? picks[b] : int'($urandom_range(0, 63));
                do_load(r0v, r1v, int'($urandom_range(0, 63)), "rnd");
            end
            do_symbol(6'($urandom), int'($urandom_range(0, 3)), "rnd");
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_symbol();
        test_notches();
        test_clamp();
        test_backpressure();
        test_reset_mid(1'b0, "rst_step");
        test_reset_mid(1'b1, "rst_out");
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
